// File: rtl/quadencodergen_pkg.sv
// Shared definitions for the quadrature generator: {A,B} phase encoding and
// single-step phase advance helpers, also used by decoder test benches.
package quadencodergen_pkg;

   typedef logic [1:0] phase_t;   // {A, B}

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   localparam phase_t PH_00 = 2'b00;
   localparam phase_t PH_10 = 2'b10;
   localparam phase_t PH_11 = 2'b11;
   localparam phase_t PH_01 = 2'b01;

   // Up order 00 -> 10 -> 11 -> 01 -> 00 keeps A leading B.
   function automatic phase_t next_phase_up(input phase_t ph);
      phase_t nxt;
      case (ph)
         PH_00:   nxt = PH_10;
         PH_10:   nxt = PH_11;
         PH_11:   nxt = PH_01;
         default: nxt = PH_00;
      endcase
      return nxt;
   endfunction

   function automatic phase_t next_phase_down(input phase_t ph);
      phase_t nxt;
      case (ph)
         PH_00:   nxt = PH_01;
         PH_01:   nxt = PH_11;
         PH_11:   nxt = PH_10;
         default: nxt = PH_00;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/quadencodergen_dds.sv
// Phase accumulator for the quadrature generator: clamps |velocity| and emits a
// combinational step request (carry) plus direction for the current edge.
module quadencodergen_dds
   import quadencodergen_pkg::*;
#(
   parameter int ACC_BITS = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic signed [ACC_BITS-1:0] velocity,
   output logic                       carry,
   output dir_t                       dir
);

   localparam logic [ACC_BITS-1:0] VEL_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
   localparam logic [ACC_BITS-1:0] MAG_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};

   logic [ACC_BITS-1:0] acc_q, acc_d;
   logic [ACC_BITS-1:0] mag;
   logic [ACC_BITS:0]   sum;

   // The most negative command has no positive twin, so it saturates.
   function automatic logic [ACC_BITS-1:0] sat_mag(input logic signed [ACC_BITS-1:0] v);
      logic signed [ACC_BITS-1:0] neg;
      neg = -v;
      if ($unsigned(v) == VEL_MIN) begin
         return MAG_MAX;
      end
      return v[ACC_BITS-1] ? $unsigned(neg) : $unsigned(v);
   endfunction

   always_comb begin
      mag   = sat_mag(velocity);
      sum   = {1'b0, acc_q} + {1'b0, mag};
      carry = enable & sum[ACC_BITS];
      dir   = velocity[ACC_BITS-1] ? DIR_DOWN : DIR_UP;
      acc_d = enable ? sum[ACC_BITS-1:0] : acc_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/quadencodergen.sv
// Quadrature encoder generator: turns a signed velocity into A/B edges, a
// once-per-revolution Z index, and the emitted position / revolution count.
module quadencodergen
   import quadencodergen_pkg::*;
#(
   parameter int BITS           = 32,
   parameter int ACC_BITS       = 32,
   parameter int COUNTS_PER_REV = 4000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic signed [ACC_BITS-1:0] velocity,
   input  logic                       pos_clear,
   output logic                       a,
   output logic                       b,
   output logic                       z,
   output logic signed [BITS-1:0]     position,
   output logic signed [15:0]         revs
);

   localparam int              RP_W    = $clog2(COUNTS_PER_REV);
   localparam logic [RP_W-1:0] RP_MAX  = RP_W'(COUNTS_PER_REV - 1);
   localparam logic [RP_W-1:0] RP_ONE  = RP_W'(1);
   localparam logic signed [BITS-1:0] POS_ONE = BITS'(1);

   logic                   step;
   dir_t                   dir;

   phase_t                 phase_q, phase_d;
   logic [RP_W-1:0]        rp_q, rp_d;
   logic signed [BITS-1:0] pos_q, pos_d;
   logic signed [15:0]     revs_q, revs_d;
   logic                   z_q, z_d;

   quadencodergen_dds #(
      .ACC_BITS (ACC_BITS)
   ) u_dds (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .velocity (velocity),
      .carry    (step),
      .dir      (dir)
   );

   // A clear wins over a coincident step; the phase is left alone so A/B never glitch.
   always_comb begin
      phase_d = phase_q;
      rp_d    = rp_q;
      pos_d   = pos_q;
      revs_d  = revs_q;
      if (pos_clear) begin
         rp_d   = '0;
         pos_d  = '0;
         revs_d = '0;
      end else if (step) begin
         if (dir == DIR_UP) begin
            phase_d = next_phase_up(phase_q);
            pos_d   = pos_q + POS_ONE;
            if (rp_q == RP_MAX) begin
               rp_d   = '0;
               revs_d = revs_q + 16'sd1;
            end else begin
               rp_d = rp_q + RP_ONE;
            end
         end else begin
            phase_d = next_phase_down(phase_q);
            pos_d   = pos_q - POS_ONE;
            if (rp_q == '0) begin
               rp_d   = RP_MAX;
               revs_d = revs_q - 16'sd1;
            end else begin
               rp_d = rp_q - RP_ONE;
            end
         end
      end
      z_d = (rp_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_00;
         rp_q    <= '0;
         pos_q   <= '0;
         revs_q  <= '0;
         z_q     <= 1'b1;
      end else begin
         phase_q <= phase_d;
         rp_q    <= rp_d;
         pos_q   <= pos_d;
         revs_q  <= revs_d;
         z_q     <= z_d;
      end
   end

   assign a        = phase_q[1];
   assign b        = phase_q[0];
   assign z        = z_q;
   assign position = pos_q;
   assign revs     = revs_q;

endmodule

// File: tb/tb_quadencodergen.sv
// Scoreboard bench for quadencodergen (COUNTS_PER_REV = 8): stimulus queues the
// expected output change and the edge it must occur on; the monitor checks each change.
module tb_quadencodergen;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               enable;
   logic signed [31:0] velocity;
   logic               pos_clear;
   logic               a, b, z;
   logic signed [31:0] position;
   logic signed [15:0] revs;

   typedef struct {
      string              name;
      int                 at_edge;
      logic               a;
      logic               b;
      logic               z;
      logic signed [31:0] pos;
      logic signed [15:0] revs;
   } exp_t;

   exp_t exp_q[$];
   int   edge_n = 0;
   int   checks = 0;
   int   fails  = 0;

   quadencodergen #(
      .BITS           (32),
      .ACC_BITS       (32),
      .COUNTS_PER_REV (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .velocity  (velocity),
      .pos_clear (pos_clear),
      .a         (a),
      .b         (b),
      .z         (z),
      .position  (position),
      .revs      (revs)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input string nm, input int d, input logic ea, input logic eb,
                           input logic ez, input int epos, input int erevs);
      exp_t e;
      e.name    = nm;
      e.at_edge = edge_n + d;
      e.a       = ea;
      e.b       = eb;
      e.z       = ez;
      e.pos     = epos;
      e.revs    = 16'(erevs);
      exp_q.push_back(e);
   endtask

   // Monitor: an output change (or the very first sample) consumes one expectation.
   initial begin
      logic [50:0] prev, cur;
      logic        primed;
      exp_t        e;
      primed = 1'b0;
      prev   = '0;
      forever begin
         @(posedge clk);
         #1;
         edge_n++;
         cur = {a, b, z, position, revs};
         if (!primed || cur != prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_change: edge %0d ab=%b%b z=%b pos=%0d revs=%0d, required no change",
                        edge_n, a, b, z, position, revs);
            end else begin
               e = exp_q.pop_front();
               if (edge_n != e.at_edge || a !== e.a || b !== e.b || z !== e.z ||
                   position !== e.pos || revs !== e.revs) begin
                  fails++;
                  $display("FAIL %s: got edge %0d ab=%b%b z=%b pos=%0d revs=%0d, required edge %0d ab=%b%b z=%b pos=%0d revs=%0d",
                           e.name, edge_n, a, b, z, position, revs,
                           e.at_edge, e.a, e.b, e.z, e.pos, e.revs);
               end
            end
            primed = 1'b1;
         end
         prev = cur;
      end
   end

   initial begin
      rst_n     = 1'b0;
      enable    = 1'b0;
      velocity  = '0;
      pos_clear = 1'b0;
      push_exp("reset", 1, 0, 0, 1, 0, 0);
      repeat (3) @(negedge clk);

      // constant rate 2^30: a step every 4 enabled edges
      rst_n    = 1'b1;
      enable   = 1'b1;
      velocity = 32'sd1073741824;
      push_exp("rate_s1", 4,  1, 0, 0, 1, 0);
      push_exp("rate_s2", 8,  1, 1, 0, 2, 0);
      push_exp("rate_s3", 12, 0, 1, 0, 3, 0);
      push_exp("rate_s4", 16, 0, 0, 0, 4, 0);
      repeat (18) @(negedge clk);

      // clamp: residue is 2^31, so true magnitude 2^31-1 first carries on the 2nd edge
      velocity = 32'sh8000_0000;
      push_exp("clamp_s1", 2,  0, 1, 0, 3, 0);
      push_exp("clamp_s2", 4,  1, 1, 0, 2, 0);
      push_exp("clamp_s3", 6,  1, 0, 0, 1, 0);
      push_exp("clamp_idx", 8, 0, 0, 1, 0, 0);
      push_exp("clamp_wrap", 10, 0, 1, 0, -1, -1);
      repeat (10) @(negedge clk);

      // asynchronous reset mid-stream, then reverse from reset
      rst_n = 1'b0;
      push_exp("midreset", 1, 0, 0, 1, 0, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      velocity = -32'sd1073741824;
      push_exp("rev_s1", 4, 0, 1, 0, -1, -1);
      push_exp("rev_s2", 8, 1, 1, 0, -2, -1);
      repeat (8) @(negedge clk);

      // clear while disabled
      enable    = 1'b0;
      pos_clear = 1'b1;
      push_exp("clear_dis", 1, 1, 1, 1, 0, 0);
      @(negedge clk);
      pos_clear = 1'b0;

      // index wrap at max rate, then one step back
      enable   = 1'b1;
      velocity = 32'sh7FFF_FFFF;
      push_exp("idx_s1", 3,  0, 1, 0, 1, 0);
      push_exp("idx_s2", 5,  0, 0, 0, 2, 0);
      push_exp("idx_s3", 7,  1, 0, 0, 3, 0);
      push_exp("idx_s4", 9,  1, 1, 0, 4, 0);
      push_exp("idx_s5", 11, 0, 1, 0, 5, 0);
      push_exp("idx_s6", 13, 0, 0, 0, 6, 0);
      push_exp("idx_s7", 15, 1, 0, 0, 7, 0);
      push_exp("idx_s8", 17, 1, 1, 1, 8, 1);
      repeat (17) @(negedge clk);
      velocity = -32'sh7FFF_FFFF;
      push_exp("idx_back", 2, 1, 0, 0, 7, 0);
      repeat (2) @(negedge clk);

      // enable low for 10 clocks keeps the residue
      velocity = 32'sd1073741824;
      push_exp("en_s1", 3, 1, 1, 1, 8, 1);
      repeat (4) @(negedge clk);
      enable   = 1'b0;
      velocity = 32'sh7FFF_FFFF;
      repeat (10) @(negedge clk);
      enable   = 1'b1;
      velocity = 32'sd1073741824;
      push_exp("en_resume", 3, 0, 1, 0, 9, 1);
      repeat (3) @(negedge clk);

      // clear on the same edge as a carry drops that step
      repeat (3) @(negedge clk);
      pos_clear = 1'b1;
      push_exp("clear_carry", 1, 0, 1, 1, 0, 0);
      @(negedge clk);
      pos_clear = 1'b0;
      push_exp("after_clear", 4, 0, 0, 0, 1, 0);
      repeat (4) @(negedge clk);

      enable = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_expectations: %0d still queued, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/quadencodergen.md
# quadencodergen

Quadrature encoder signal generator: the transmit-side counterpart of the quadencoderz2 decoder. It converts a signed velocity command into A/B quadrature edges plus a once-per-revolution Z index pulse, and reports the position it has emitted. It is used as a simulated encoder for loopback testing of the decoder chain and for stepper/encoder emulation outputs.

## Interface
- BITS, 32: width of the signed position output.
- ACC_BITS, 32: width of the phase accumulator; velocity width equals ACC_BITS.
- COUNTS_PER_REV, 4000: quadrature counts (4x edges) per revolution; must be ≥ 4.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- enable  in  1  high = generate; low = freeze accumulator, phase, outputs.
- velocity  in  ACC_BITS signed  counts per clock, scaled by 2^ACC_BITS; sign selects direction.
- pos_clear  in  1  synchronous clear of position, rev-position and revs.
- a, b, z  out  1 each  registered quadrature and index outputs.
- position  out  BITS signed  emitted count total.
- revs  out  16 signed  whole revolutions emitted, wraps mod 2^16.

## Operation
- Magnitude: mag = |velocity|; velocity = -2^(ACC_BITS-1) is clamped to mag = 2^(ACC_BITS-1)-1. Maximum step rate is therefore below one count per clk.
- Accumulator: each enabled edge, {carry, acc} <= acc + mag. A carry produces exactly one step in direction dir = (velocity ≥ 0) ? up : down. Velocity and dir are sampled on the same edge.
- Phase: a 2-bit state with AB sequence up: 00→10→11→01→00 (A leads B); down is the reverse. Only one of A/B changes per step. Decoder convention: up means (A_new ^ B_old) = 1.
- Rev position rp is 0..COUNTS_PER_REV-1.
  - Up step: rp wraps CPR-1→0 and increments revs.
  - Down step: rp wraps 0→CPR-1 and decrements revs.
  - position ±1 per step, wrapping in two's complement.
- z = 1 exactly while rp == 0, i.e. for one quadrature state per revolution in either direction.
- pos_clear (enabled or not):
  - position, rp and revs go to 0; z goes to 1.
  - The phase and accumulator are not changed, so there is no glitch on A/B.
  - pos_clear takes priority over a simultaneous step; that step is dropped.
- enable = 0: all state held, and velocity is ignored.
- Reset values: acc = 0, phase AB = 00, rp = 0, position = 0, revs = 0. Outputs a = 0, b = 0, z = 1.

## Timing
- a/b/z/position/revs all update on the same edge as the accumulator carry, with no extra pipeline stage.
- A velocity change takes effect on the next enabled edge. The accumulator residue is kept, so there is no phase reset.
- Step interval is floor or ceil of 2^ACC_BITS / mag clocks. The minimum A/B edge spacing is 2 clks at the clamp limit. The consuming decoder's 2-flop synchronizer is therefore met only for mag ≤ 2^(ACC_BITS-2); above that, behaviour is defined but the decoder is not guaranteed to count.
- Direction reversal between consecutive steps is legal: the phase returns to the previous state and position returns to its previous value.
- An asynchronous reset mid-stream forces the reset values immediately. Generation restarts from AB = 00 on the first enabled edge after release.

## Structure
- Package quadencodergen_pkg holds the following, shared with decoder test benches:
  - phase encoding constants PH_00, PH_10, PH_11, PH_01;
  - functions next_phase_up / next_phase_down.
- Sub-module quadencodergen_dds holds the accumulator, magnitude clamp and carry/dir outputs. The top holds the phase, rp, position and revs.

## Test plan
- **Reset / constant rate:** reset, then enable with velocity = 2^30. Required: first step at enabled edge 4, then every 4 clks. AB goes 10, 11, 01, 00. position = 1, 2, 3, 4. z falls on the first step.
- **Reverse from reset:** velocity = -2^30. Required: AB 01 at edge 4, then 11; position = -1, -2; rp = CPR-1; revs = -1; z low.
- **Index wrap with COUNTS_PER_REV = 8, velocity = 2^31-1:** after 8 up steps, z is high for exactly one step interval, revs = 1, position = 8. Reversing for 1 step gives revs = 0 and z low.
- **Clamp:** velocity = -2^31 behaves exactly like magnitude 2^31-1, downward. Required: never two steps on adjacent clocks.
- **enable low mid-stream:** outputs and position frozen for 10 clks. On re-enable, the next step occurs at the original residue-determined edge.
- **pos_clear on the same edge as a carry:** required position = 0, revs = 0, z = 1, AB unchanged. The loopback quadencoderz2 sees no count_enable on that edge.
